// File: rtl/dm_hart_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm_hart_ctrl : debug-module run control (halt/resume/havereset) per hart.
// Optional hart-array selection enabled by macro DM_HART_ARRAY_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dm_hart_ctrl #(
   parameter int NR_HARTS  = 4,
   parameter int HARTSEL_W = 20
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 dmactive_i,
   input  logic [HARTSEL_W-1:0] hartsel_i,
   input  logic                 hasel_i,
   input  logic [NR_HARTS-1:0]  hawindow_i,
   input  logic                 haltreq_i,
   input  logic                 resumereq_i,
   input  logic                 ackhavereset_i,
   input  logic [NR_HARTS-1:0]  halted_set_i,
   input  logic [NR_HARTS-1:0]  resuming_set_i,
   input  logic [NR_HARTS-1:0]  hart_reset_i,
   output logic [NR_HARTS-1:0]  debug_req_o,
   output logic [NR_HARTS-1:0]  resume_o,
   output logic [NR_HARTS-1:0]  halted_o,
   output logic [NR_HARTS-1:0]  resumeack_o,
   output logic [NR_HARTS-1:0]  havereset_o,
   output logic [6:0]           summary_o
);

   localparam logic [1:0] c_ST_RUNNING    = 2'd0;
   localparam logic [1:0] c_ST_HALT_REQ   = 2'd1;
   localparam logic [1:0] c_ST_HALTED     = 2'd2;
   localparam logic [1:0] c_ST_RESUME_REQ = 2'd3;
   // Comparison width wide enough to hold NR_HARTS even for tiny HARTSEL_W
   localparam int c_CMP_W = (HARTSEL_W > 6) ? HARTSEL_W : 6;

   logic [c_CMP_W-1:0]  w_hartsel;
   logic [NR_HARTS-1:0] w_window;
   logic [NR_HARTS-1:0] w_sel;

   assign w_hartsel = c_CMP_W'(hartsel_i);

`ifdef DM_HART_ARRAY_EN
   assign w_window = hawindow_i & {NR_HARTS{hasel_i}};
`else
   logic w_unused_array;
   assign w_window       = '0;
   assign w_unused_array = ^{hasel_i, hawindow_i};
`endif

   for (genvar h = 0; h < NR_HARTS; h++) begin : g_hart
      logic [1:0] r_state;
      logic [1:0] w_state_nxt;
      logic       r_rack;
      logic       w_rack_nxt;
      logic       r_hrst;
      logic       w_hrst_nxt;
      logic       w_dbg;
      logic       w_resume;
      logic       w_halted;

      assign w_sel[h] = (w_hartsel == c_CMP_W'(h)) | w_window[h];

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            r_state <= c_ST_RUNNING;
            r_rack  <= 1'b0;
            r_hrst  <= 1'b1;
         end else begin
            r_state <= w_state_nxt;
            r_rack  <= w_rack_nxt;
            r_hrst  <= w_hrst_nxt;
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_rack_nxt  = r_rack;
         w_hrst_nxt  = r_hrst;
         if (hart_reset_i[h]) begin
            w_hrst_nxt = 1'b1;
         end else if (ackhavereset_i && w_sel[h]) begin
            w_hrst_nxt = 1'b0;
         end
         if (hart_reset_i[h]) begin
            w_state_nxt = c_ST_RUNNING;
         end else if (!dmactive_i) begin
            w_state_nxt = c_ST_RUNNING;
            w_rack_nxt  = 1'b0;
         end else begin
            case (r_state)
               c_ST_RUNNING: begin
                  if (halted_set_i[h])              w_state_nxt = c_ST_HALTED;
                  else if (haltreq_i && w_sel[h])   w_state_nxt = c_ST_HALT_REQ;
               end
               c_ST_HALT_REQ: begin
                  if (halted_set_i[h])              w_state_nxt = c_ST_HALTED;
                  else if (!(haltreq_i && w_sel[h])) w_state_nxt = c_ST_RUNNING;
               end
               c_ST_HALTED: begin
                  // Halt takes priority: a pending haltreq masks resumereq
                  if (resumereq_i && w_sel[h] && !haltreq_i) begin
                     w_state_nxt = c_ST_RESUME_REQ;
                     w_rack_nxt  = 1'b0;
                  end
               end
               c_ST_RESUME_REQ: begin
                  if (halted_set_i[h]) begin
                     w_state_nxt = c_ST_HALTED;
                  end else if (resuming_set_i[h]) begin
                     w_state_nxt = c_ST_RUNNING;
                     w_rack_nxt  = 1'b1;
                  end
               end
               default: w_state_nxt = c_ST_RUNNING;
            endcase
         end
      end

      always_comb begin
         w_dbg    = (r_state == c_ST_HALT_REQ);
         w_resume = (r_state == c_ST_RESUME_REQ);
         w_halted = (r_state == c_ST_HALTED) || (r_state == c_ST_RESUME_REQ);
      end

      assign debug_req_o[h] = w_dbg;
      assign resume_o[h]    = w_resume;
      assign halted_o[h]    = w_halted;
      assign resumeack_o[h] = r_rack;
      assign havereset_o[h] = r_hrst;
   end

   logic                w_anysel;
   logic [NR_HARTS-1:0] w_running;

   assign w_anysel  = |w_sel;
   assign w_running = ~halted_o;

   assign summary_o = {
      (w_hartsel >= c_CMP_W'(NR_HARTS)),
      w_anysel & (~|(w_sel & ~halted_o)),
      |(w_sel & halted_o),
      w_anysel & (~|(w_sel & ~w_running)),
      |(w_sel & w_running),
      w_anysel & (~|(w_sel & ~resumeack_o)),
      |(w_sel & resumeack_o)
   };

endmodule
`default_nettype wire

// File: tb/tb_dm_hart_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dm_hart_ctrl : directed vector table, corner sequences and random run
// against a flag-based reference model. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dm_hart_ctrl;
   localparam int NR = 4;
   localparam int HW = 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          dmactive;
   logic [HW-1:0] hartsel;
   logic          hasel;
   logic [NR-1:0] hawindow;
   logic          haltreq, resumereq, ack;
   logic [NR-1:0] hset, rset, hrst;
   logic [NR-1:0] dbg_o, res_o, hlt_o, rack_o, hrs_o;
   logic [6:0]    sum_o;

   always #5 clk = ~clk;

   dm_hart_ctrl #(.NR_HARTS(NR), .HARTSEL_W(HW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive), .hartsel_i(hartsel),
      .hasel_i(hasel), .hawindow_i(hawindow), .haltreq_i(haltreq),
      .resumereq_i(resumereq), .ackhavereset_i(ack), .halted_set_i(hset),
      .resuming_set_i(rset), .hart_reset_i(hrst), .debug_req_o(dbg_o),
      .resume_o(res_o), .halted_o(hlt_o), .resumeack_o(rack_o),
      .havereset_o(hrs_o), .summary_o(sum_o)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: plain per-hart flags
   logic [NR-1:0] m_dbg, m_halted, m_resume, m_rack, m_hrst;

   function automatic logic [NR-1:0] msel();
      logic [NR-1:0] s;
      for (int h = 0; h < NR; h++) begin
         s[h] = (hartsel == HW'(h));
`ifdef DM_HART_ARRAY_EN
         s[h] = s[h] | (hasel & hawindow[h]);
`endif
      end
      return s;
   endfunction

   function automatic logic [6:0] msum();
      logic [NR-1:0] s;
      int nsel, nh, nr, na;
      s = msel();
      nsel = 0; nh = 0; nr = 0; na = 0;
      for (int h = 0; h < NR; h++) begin
         if (s[h]) begin
            nsel++;
            if (m_halted[h]) nh++; else nr++;
            if (m_rack[h]) na++;
         end
      end
      return {hartsel >= HW'(NR), nsel > 0 && nh == nsel, nh > 0,
              nsel > 0 && nr == nsel, nr > 0, nsel > 0 && na == nsel, na > 0};
   endfunction

   task automatic model_step();
      logic [NR-1:0] s;
      s = msel();
      if (!rst_n) begin
         m_dbg = '0; m_halted = '0; m_resume = '0; m_rack = '0; m_hrst = '1;
         return;
      end
      for (int h = 0; h < NR; h++) begin
         if (hrst[h]) m_hrst[h] = 1'b1;
         else if (ack && s[h]) m_hrst[h] = 1'b0;
         if (hrst[h]) begin
            m_dbg[h] = 1'b0; m_halted[h] = 1'b0; m_resume[h] = 1'b0;
         end else if (!dmactive) begin
            m_dbg[h] = 1'b0; m_halted[h] = 1'b0; m_resume[h] = 1'b0; m_rack[h] = 1'b0;
         end else if (hset[h] && !(m_halted[h] && !m_resume[h])) begin
            m_dbg[h] = 1'b0; m_halted[h] = 1'b1; m_resume[h] = 1'b0;
         end else if (m_resume[h]) begin
            if (rset[h]) begin
               m_resume[h] = 1'b0; m_halted[h] = 1'b0; m_rack[h] = 1'b1;
            end
         end else if (m_halted[h]) begin
            if (resumereq && s[h] && !haltreq) begin
               m_resume[h] = 1'b1; m_rack[h] = 1'b0;
            end
         end else begin
            m_dbg[h] = haltreq && s[h];
         end
      end
   endtask

   task automatic idle();
      rst_n = 1'b1; dmactive = 1'b1; hartsel = '0; hasel = 1'b0; hawindow = '0;
      haltreq = 1'b0; resumereq = 1'b0; ack = 1'b0; hset = '0; rset = '0; hrst = '0;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [NR-1:0] e_dbg, input logic [NR-1:0] e_res,
                          input logic [NR-1:0] e_hlt, input logic [NR-1:0] e_rack,
                          input logic [NR-1:0] e_hrs, input logic [6:0] e_sum);
      chk({tag, ".debug_req"}, 32'(dbg_o), 32'(e_dbg));
      chk({tag, ".resume"}, 32'(res_o), 32'(e_res));
      chk({tag, ".halted"}, 32'(hlt_o), 32'(e_hlt));
      chk({tag, ".resumeack"}, 32'(rack_o), 32'(e_rack));
      chk({tag, ".havereset"}, 32'(hrs_o), 32'(e_hrs));
      chk({tag, ".summary"}, 32'(sum_o), 32'(e_sum));
   endtask

   typedef struct {
      int            hs;
      logic          hr, rr, ak;
      logic [NR-1:0] hset, rset, hrst;
      logic [NR-1:0] e_dbg, e_res, e_hlt, e_rack, e_hrs;
      logic [6:0]    e_sum;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(input int hs, input logic hr, input logic rr, input logic ak,
                               input logic [NR-1:0] hs_set, input logic [NR-1:0] rs_set,
                               input logic [NR-1:0] h_rst, input logic [NR-1:0] e_dbg,
                               input logic [NR-1:0] e_res, input logic [NR-1:0] e_hlt,
                               input logic [NR-1:0] e_rack, input logic [NR-1:0] e_hrs,
                               input logic [6:0] e_sum);
      vec_t v;
      v.hs = hs; v.hr = hr; v.rr = rr; v.ak = ak;
      v.hset = hs_set; v.rset = rs_set; v.hrst = h_rst;
      v.e_dbg = e_dbg; v.e_res = e_res; v.e_hlt = e_hlt;
      v.e_rack = e_rack; v.e_hrs = e_hrs; v.e_sum = e_sum;
      return v;
   endfunction

   initial begin
      //            hs hr rr ak hset    rset    hrst    dbg     res     hlt     rack    hrs     summary
      tbl[0]  = mk(2, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 7'b0001100);
      tbl[1]  = mk(2, 1, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1111, 7'b0110000);
      tbl[2]  = mk(2, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1111, 7'b0110000);
      tbl[3]  = mk(2, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1111, 7'b0110000);
      tbl[4]  = mk(2, 0, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1111, 7'b0001111);
      tbl[5]  = mk(7, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1111, 7'b1000000);
      tbl[6]  = mk(7, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1111, 7'b1000000);
      tbl[7]  = mk(1, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1111, 7'b0001100);
      tbl[8]  = mk(1, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1101, 7'b0001100);
      tbl[9]  = mk(0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b1101, 7'b0001100);
      tbl[10] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1101, 7'b0001100);
      tbl[11] = mk(0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b1101, 7'b0001100);
      tbl[12] = mk(0, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b1101, 7'b0110000);
      tbl[13] = mk(0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b1101, 7'b0110000);
      tbl[14] = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b1101, 7'b0110000);

      idle();
      rst_n = 1'b0;
      step();
      step();
      chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 7'b0001100);

      for (int i = 0; i < 15; i++) begin
         idle();
         hartsel = HW'(tbl[i].hs); haltreq = tbl[i].hr; resumereq = tbl[i].rr; ack = tbl[i].ak;
         hset = tbl[i].hset; rset = tbl[i].rset; hrst = tbl[i].hrst;
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].e_dbg, tbl[i].e_res, tbl[i].e_hlt,
                 tbl[i].e_rack, tbl[i].e_hrs, tbl[i].e_sum);
      end

      // Reset while hart 0 waits in RESUME_REQ
      idle(); rst_n = 1'b0; step();
      chk_all("midreset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 7'b0001100);
      idle(); rset = 4'b0001; step();
      chk_all("post_rst_rset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 7'b0001100);
      idle(); haltreq = 1'b1; step();
      chk("post_rst_halt.debug_req", 32'(dbg_o), 32'h1);

      // Deactivating the DM drops run control but keeps havereset
      idle(); haltreq = 1'b1; hset = 4'b0001; step();
      chk("pre_inactive.halted", 32'(hlt_o), 32'h1);
      idle(); dmactive = 1'b0; haltreq = 1'b1; step();
      chk_all("inactive", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 7'b0001100);

`ifdef DM_HART_ARRAY_EN
      idle(); hasel = 1'b1; hawindow = 4'b1011; haltreq = 1'b1; step();
      chk("array.debug_req", 32'(dbg_o), 32'hb);
      idle(); hasel = 1'b1; hawindow = 4'b1011; haltreq = 1'b1; hset = 4'b0011; step();
      chk("array.halted", 32'(hlt_o), 32'h3);
      chk("array.anyhalted", 32'(sum_o[4]), 32'h1);
      chk("array.allhalted", 32'(sum_o[5]), 32'h0);
`endif

      idle(); rst_n = 1'b0; step();
      for (int c = 0; c < 3000; c++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         dmactive  = ($urandom_range(0, 29) != 0);
         hartsel   = HW'($urandom_range(0, 5));
         hasel     = 1'($urandom_range(0, 1));
         hawindow  = NR'($urandom);
         haltreq   = ($urandom_range(0, 2) == 0);
         resumereq = ($urandom_range(0, 3) == 0);
         ack       = ($urandom_range(0, 7) == 0);
         for (int h = 0; h < NR; h++) begin
            hset[h] = ($urandom_range(0, 5) == 0);
            rset[h] = ($urandom_range(0, 3) == 0);
            hrst[h] = ($urandom_range(0, 39) == 0);
         end
         step();
         chk_all($sformatf("rand%0d", c), m_dbg, m_resume, m_halted, m_rack, m_hrst, msum());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
